// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the serial add/sub sequencer
package alu_pkg;

   localparam int   NIBBLE_W = 4;
   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// rtl/nibble_addsub_slice.sv - combinational 4-bit add/sub slice exposing carry-out and carry into the MSB
module nibble_addsub_slice
   import alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A4,
   input  logic [NIBBLE_W-1:0] B4,
   input  logic                Op,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] S4,
   output logic                c3,
   output logic                c2
);

   logic [NIBBLE_W-1:0] bx;
   logic [NIBBLE_W-1:0] lo;

   // Low three bits are added with a spare bit on top so the carry into the MSB is visible for overflow.
   always_comb begin
      bx = (Op == OP_ADD) ? B4 : ~B4;
      lo = {1'b0, A4[2:0]} + {1'b0, bx[2:0]} + {3'b000, Cin};
      c2 = lo[3];
      S4 = {A4[3] ^ bx[3] ^ c2, lo[2:0]};
      c3 = (A4[3] & bx[3]) | (c2 & (A4[3] ^ bx[3]));
   end

endmodule

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - wide add/sub sequenced one nibble per clock through a single slice
// Optional zero flag output Z enabled by defining ALU_ZERO_FLAG_EN.
module alu_serial_sequencer
   import alu_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         In_Valid,
   output logic                         In_Ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  A,
   input  logic [NIBBLE_W*NIBBLES-1:0]  B,
   input  logic                         Op,
   output logic                         Out_Valid,
   input  logic                         Out_Ready,
   output logic [NIBBLE_W*NIBBLES-1:0]  S,
   output logic                         C,
`ifdef ALU_ZERO_FLAG_EN
   output logic                         Z,
`endif
   output logic                         V
);

   localparam int               W        = NIBBLE_W * NIBBLES;
   localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t                state, state_nxt;
   logic [W-1:0]          a_q, b_q;
   logic                  op_q;
   logic                  carry_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NIBBLE_W-1:0]   a_nib, b_nib, slice_s;
   logic                  slice_c3, slice_c2;
   logic                  accept;
   logic                  last_slice;

   assign a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
   assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

   nibble_addsub_slice u_slice (
      .A4  (a_nib),
      .B4  (b_nib),
      .Op  (op_q),
      .Cin (carry_q),
      .S4  (slice_s),
      .c3  (slice_c3),
      .c2  (slice_c2)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake outputs decode straight from the state register, so they never depend on inputs.
   always_comb begin
      state_nxt  = state;
      In_Ready   = 1'b0;
      Out_Valid  = 1'b0;
      accept     = 1'b0;
      last_slice = 1'b0;
      case (state)
         ST_IDLE: begin
            In_Ready = 1'b1;
            if (In_Valid) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (idx_q == IDX_LAST) begin
               last_slice = 1'b1;
               state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            Out_Valid = 1'b1;
            if (Out_Ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         S       <= '0;
         C       <= 1'b0;
         V       <= 1'b0;
      end else if (accept) begin
         a_q     <= A;
         b_q     <= B;
         op_q    <= Op;
         carry_q <= (Op == OP_SUB);
         idx_q   <= '0;
         S       <= '0;
      end else if (state == ST_RUN) begin
         S[NIBBLE_W*idx_q +: NIBBLE_W] <= slice_s;
         carry_q                       <= slice_c3;
         if (last_slice) begin
            C <= slice_c3 ^ op_q;
            V <= slice_c3 ^ slice_c2;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

`ifdef ALU_ZERO_FLAG_EN
   logic [W-1:0] s_full;

   // The final nibble is not in S yet on the last RUN edge, so merge it before testing for zero.
   always_comb begin
      s_full                            = S;
      s_full[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Z <= 1'b0;
      end else if (last_slice) begin
         Z <= (s_full == '0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb/tb_alu_serial_sequencer.sv - directed table-driven bench for the serial add/sub sequencer
module tb_alu_serial_sequencer;
   import alu_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        In_Valid;
   logic        In_Ready;
   logic [15:0] A, B;
   logic        Op;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [15:0] S;
   logic        C, V;
`ifdef ALU_ZERO_FLAG_EN
   logic        Z;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] s;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs [10];

   always #5 Clk = ~Clk;

   alu_serial_sequencer #(.NIBBLES(4)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .A         (A),
      .B         (B),
      .Op        (Op),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .S         (S),
      .C         (C),
`ifdef ALU_ZERO_FLAG_EN
      .Z         (Z),
`endif
      .V         (V)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op, output int lat);
      @(negedge Clk);
      chk("in_ready_before_accept", {31'd0, In_Ready}, 32'd1);
      A        = a;
      B        = b;
      Op       = op;
      In_Valid = 1'b1;
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      lat      = 1;
      while (!Out_Valid && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      chk("out_valid_seen", {31'd0, Out_Valid}, 32'd1);
   endtask

   task automatic release_out();
      @(negedge Clk);
      Out_Ready = 1'b1;
      @(posedge Clk);
      #1;
      Out_Ready = 1'b0;
      chk("release_in_ready", {31'd0, In_Ready}, 32'd1);
      chk("release_out_valid", {31'd0, Out_Valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      vecs[0] = '{16'h1234, 16'h0FFF, OP_ADD, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 1'b1, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b0, 1'b1};
      vecs[5] = '{16'h1234, 16'h1234, OP_SUB, 16'h0000, 1'b0, 1'b0};
      vecs[6] = '{16'h0001, 16'h0000, OP_ADD, 16'h0001, 1'b0, 1'b0};
      vecs[7] = '{16'h5A5A, 16'hA5A5, OP_ADD, 16'hFFFF, 1'b0, 1'b0};
      vecs[8] = '{16'h4000, 16'h4000, OP_ADD, 16'h8000, 1'b0, 1'b1};
      vecs[9] = '{16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b1, 1'b0};

      Reset_n   = 1'b0;
      In_Valid  = 1'b0;
      Out_Ready = 1'b0;
      A         = '0;
      B         = '0;
      Op        = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
      chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
      chk("rst_s", {16'd0, S}, 32'd0);
      chk("rst_c", {31'd0, C}, 32'd0);
      chk("rst_v", {31'd0, V}, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
      chk("rst_z", {31'd0, Z}, 32'd0);
`endif
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
         chk($sformatf("vec%0d_latency", i), lat, 32'd5);
         chk($sformatf("vec%0d_s", i), {16'd0, S}, {16'd0, vecs[i].s});
         chk($sformatf("vec%0d_c", i), {31'd0, C}, {31'd0, vecs[i].c});
         chk($sformatf("vec%0d_v", i), {31'd0, V}, {31'd0, vecs[i].v});
         chk($sformatf("vec%0d_in_ready_done", i), {31'd0, In_Ready}, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
         chk($sformatf("vec%0d_z", i), {31'd0, Z}, {31'd0, (vecs[i].s == 16'h0000)});
`endif
         release_out();
      end

      // Result held while the consumer stalls; new operands offered meanwhile must be ignored.
      run_op(16'h7FFF, 16'h0001, OP_ADD, lat);
      @(negedge Clk);
      A        = 16'hFFFF;
      B        = 16'hFFFF;
      In_Valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk);
         #1;
         chk($sformatf("hold%0d_s", k), {16'd0, S}, 32'h8000);
         chk($sformatf("hold%0d_cv", k), {30'd0, C, V}, 32'd1);
         chk($sformatf("hold%0d_in_ready", k), {31'd0, In_Ready}, 32'd0);
         chk($sformatf("hold%0d_out_valid", k), {31'd0, Out_Valid}, 32'd1);
      end
      @(negedge Clk);
      In_Valid = 1'b0;
      release_out();
      @(posedge Clk);
      #1;
      chk("idle_stays_idle", {31'd0, In_Ready}, 32'd1);

      // Asynchronous reset during the second RUN cycle abandons the operation.
      @(negedge Clk);
      A        = 16'h1234;
      B        = 16'h0FFF;
      Op       = OP_ADD;
      In_Valid = 1'b1;
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("midrst_s", {16'd0, S}, 32'd0);
      chk("midrst_c", {31'd0, C}, 32'd0);
      chk("midrst_v", {31'd0, V}, 32'd0);
      chk("midrst_in_ready", {31'd0, In_Ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, Out_Valid}, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      run_op(16'h0005, 16'h0007, OP_SUB, lat);
      chk("postrst_latency", lat, 32'd5);
      chk("postrst_s", {16'd0, S}, 32'hFFFE);
      chk("postrst_cv", {30'd0, C, V}, 32'd2);
      release_out();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
